// File: rtl/instr_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// instr_fetch_ctrl
//   Fetch-side consumer of the PC generator. Issues in-order instruction
//   memory reads for the current PC over a valid/ready request bus, queues
//   each accepted PC with its returned instruction word, and hands the pair
//   to the ID stage. It also drives the PC-generator enable and handles EX
//   redirects, discarding any responses still in flight when a flush hits.
//
// Ports
//   clk               rising-edge clock
//   i_rst_n_IF        asynchronous active-low reset
//   i_pc_IF           current PC from the PC generator
//   i_pcplus4_IF      PC+4 from the PC generator
//   i_flush_IF        EX redirect; the PC generator loads the target itself
//   o_en_IF           PC-generator enable (advance or load redirect target)
//   o_imem_req_valid  read request valid
//   o_imem_req_addr   read address (the current PC)
//   i_imem_req_ready  memory accepts the request
//   i_imem_rsp_valid  read data valid, responses return in request order
//   i_imem_rsp_data   instruction word
//   o_valid_ID        instruction/PC valid toward ID
//   i_ready_ID        ID accepts the head entry
//   o_instr_ID        instruction of the head entry
//   o_pc_ID           PC of the head entry
//   o_pcplus4_ID      PC+4 of the head entry
// ----------------------------------------------------------------------------
module instr_fetch_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              i_rst_n_IF,
  input  logic [ADDR_W-1:0] i_pc_IF,
  input  logic [ADDR_W-1:0] i_pcplus4_IF,
  input  logic              i_flush_IF,
  output logic              o_en_IF,
  output logic              o_imem_req_valid,
  output logic [ADDR_W-1:0] o_imem_req_addr,
  input  logic              i_imem_req_ready,
  input  logic              i_imem_rsp_valid,
  input  logic [DATA_W-1:0] i_imem_rsp_data,
  output logic              o_valid_ID,
  input  logic              i_ready_ID,
  output logic [DATA_W-1:0] o_instr_ID,
  output logic [ADDR_W-1:0] o_pc_ID,
  output logic [ADDR_W-1:0] o_pcplus4_ID
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  // Queue storage: one slot per allocated request
  logic [ADDR_W-1:0]    pc_q      [BUF_DEPTH];
  logic [ADDR_W-1:0]    pcplus4_q [BUF_DEPTH];
  logic [DATA_W-1:0]    instr_q   [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] filled_q;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] fill_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // count    = allocated entries (filled or waiting for data)
  // out_cnt  = allocated entries still waiting for their response
  // drop_cnt = responses owed by memory for requests killed by a flush
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] out_cnt;
  logic [CNT_W-1:0] drop_cnt;

  logic [CNT_W:0]   occupancy;
  logic [CNT_W:0]   drop_after_flush;
  logic             room;
  logic             accept;
  logic             rsp_drop;
  logic             rsp_fill;
  logic             rsp_any;
  logic             pop;

  // Killed-but-owed responses still hold a slot, so a new request is only
  // issued when queued entries plus pending drops leave space. Everything
  // here depends on registered state, never on i_ready_ID, so a pop cannot
  // free a slot for a request in the same cycle.
  assign occupancy        = {1'b0, count} + {1'b0, drop_cnt};
  assign room             = occupancy < (CNT_W+1)'(BUF_DEPTH);
  assign o_imem_req_valid = i_rst_n_IF & ~i_flush_IF & room;
  assign o_imem_req_addr  = i_pc_IF;
  assign accept           = o_imem_req_valid & i_imem_req_ready;
  assign o_en_IF          = accept | (i_rst_n_IF & i_flush_IF);

  // A response pays off a pending drop first; only then does it fill the
  // oldest unfilled entry. A response with nothing owed is ignored.
  assign rsp_drop = i_imem_rsp_valid & (drop_cnt != '0);
  assign rsp_fill = i_imem_rsp_valid & (drop_cnt == '0) & (out_cnt != '0);
  assign rsp_any  = rsp_drop | rsp_fill;

  // On a flush every unfilled entry becomes a pending drop, less the
  // response (if any) that is arriving in the flush cycle itself.
  assign drop_after_flush = {1'b0, drop_cnt} + {1'b0, out_cnt} - (CNT_W+1)'(rsp_any);

  // Head entry is presented straight from the registered queue
  assign o_valid_ID   = filled_q[rd_ptr] & ~i_flush_IF;
  assign pop          = o_valid_ID & i_ready_ID;
  assign o_instr_ID   = instr_q[rd_ptr];
  assign o_pc_ID      = pc_q[rd_ptr];
  assign o_pcplus4_ID = pcplus4_q[rd_ptr];

  // Queue, pointer and counter update. Allocation, fill and pop touch
  // different slots whenever they coincide, so their writes never collide.
  always_ff @(posedge clk or negedge i_rst_n_IF) begin
    if (!i_rst_n_IF) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        pc_q[i]      <= '0;
        pcplus4_q[i] <= '0;
        instr_q[i]   <= '0;
      end
      filled_q <= '0;
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_cnt  <= '0;
      drop_cnt <= '0;
    end else if (i_flush_IF) begin
      filled_q <= '0;
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_cnt  <= '0;
      drop_cnt <= drop_after_flush[CNT_W-1:0];
    end else begin
      if (accept) begin
        pc_q[wr_ptr]      <= i_pc_IF;
        pcplus4_q[wr_ptr] <= i_pcplus4_IF;
        filled_q[wr_ptr]  <= 1'b0;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (rsp_fill) begin
        instr_q[fill_ptr]  <= i_imem_rsp_data;
        filled_q[fill_ptr] <= 1'b1;
        fill_ptr           <= fill_ptr + PTR_W'(1);
      end
      if (pop) begin
        filled_q[rd_ptr] <= 1'b0;
        rd_ptr           <= rd_ptr + PTR_W'(1);
      end
      if (rsp_drop) begin
        drop_cnt <= drop_cnt - CNT_W'(1);
      end
      count   <= count + CNT_W'(accept) - CNT_W'(pop);
      out_cnt <= out_cnt + CNT_W'(accept) - CNT_W'(rsp_fill);
    end
  end

endmodule
